vec_lane_sequencer: RTL and testbench
=====================================

Name: vec_lane_sequencer

Overview:
Sequences the 256-bit vector ALU operations VADD, VDOT and SMUL lane-by-lane through one shared half-precision scalar FPU (add/mul) using a req/ack handshake. It sits between instruction decode and the scalar float unit, replacing per-lane replicated float logic. It latches its operands on start and assembles the 256-bit result, raising a one-cycle done pulse when finished.

Parameters:
LANES, 16, number of 16-bit half-precision lanes per vector
LANE_W, 16, lane width in bits (LANES*LANE_W = 256)
ACC_INIT, 16'h0000, VDOT accumulator initial value (+0.0)

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  synchronous reset, active-high
start  in  1  request an operation; accepted only in IDLE
opcode  in  4  0000 VADD, 0001 VDOT, 0010 SMUL; all others illegal
op_1  in  256  vector operand A (SMUL: scalar in op_1[15:0])
op_2  in  256  vector operand B
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when result is valid
illegal  out  1  valid with done; 1 if opcode was unsupported
result  out  256  assembled result; holds until next accepted start
fpu_req  out  1  scalar FPU request
fpu_op  out  1  0 = add, 1 = mul
fpu_a  out  16  FPU operand A
fpu_b  out  16  FPU operand B
fpu_ack  in  1  FPU completion; fpu_res valid this cycle
fpu_res  in  16  FPU result

Behaviour:
- Reset: state IDLE; busy, done, illegal, fpu_req = 0; result, fpu_a, fpu_b = 0; fpu_op = 0; lane counter and accumulator cleared.
- States: IDLE, RUN, DONE. start high in IDLE (cycle 0) latches opcode, op_1, op_2; result cleared to 0; acc = ACC_INIT; lane = 0. Legal opcode -> RUN; illegal -> DONE with illegal=1, no fpu_req issued.
- RUN: fpu_req=1 with fpu_op/fpu_a/fpu_b held stable until a cycle with fpu_req & fpu_ack. That cycle completes the op and captures fpu_res; next op is presented the following cycle with fpu_req still high (back-to-back). fpu_ack ignored when fpu_req=0.
- VADD: per lane i (0..15 ascending): add(A_i, B_i) -> result[16i+15:16i].
- SMUL: per lane i: mul(op_1[15:0], B_i) -> result lane i.
- VDOT: per lane i: mul(A_i, B_i) -> prod; then add(acc, prod) -> acc. Order fixed lane 0..15 (float addition non-associative). Final result = {240'b0, acc}.
- After the last op completes -> DONE: done=1 for exactly one cycle, illegal valid, busy=1; next cycle IDLE, busy=0.
- Latency with zero-wait FPU (ack same cycle as req): VADD/SMUL reqs cycles 1..16, done cycle 17; VDOT reqs 1..32, done 33; illegal done cycle 1. Each FPU wait cycle adds one cycle.
- start while busy (including DONE cycle) ignored; latched operands unaffected by input changes.
- rst mid-operation: next cycle IDLE with reset values, fpu_req=0, no done pulse; a pending fpu_ack is discarded.
- Lane counter wraps never: terminal at LANES-1 (VDOT: after the add phase of lane 15).

Test Plan:
- VADD, op_1 = op_2 = all lanes 16'h3C00 (1.0), zero-wait FPU model -> every result lane 16'h4000, done at cycle 17, illegal=0, exactly 16 fpu_req&ack cycles.
- VDOT, op_1 lanes 16'h3C00, op_2 lanes 16'h4000 -> fpu_op alternates 1,0 over 32 ops, result = {240'b0, 16'h5000} (32.0), done at cycle 33.
- SMUL, op_1[15:0]=16'h4000, op_2 lanes 16'h4200 -> every lane 16'h4600 (6.0); fpu_a = 16'h4000 on every op.
- VADD with FPU ack delayed 3 cycles per op -> fpu_req held, fpu_a/fpu_b stable across waits, done at cycle 65, result matches zero-wait case.
- opcode 4'b0100 -> done and illegal high at cycle 1, result 0, fpu_req never asserted; start pulsed during a VADD run ignored -> single done.
- rst asserted at cycle 8 of a VDOT -> cycle 9 busy=0, fpu_req=0, result=0, no done; a new VADD then completes normally.

Source files
------------

// File: rtl/vec_lane_sequencer.sv
// Lane-serial sequencer for 256-bit VADD/VDOT/SMUL over one shared half-precision FPU.
// state | meaning: IDLE = waiting for start, RUN = issuing lane ops to FPU, DONE = one-cycle result pulse
module vec_lane_sequencer #(
  parameter int                LANES    = 16,
  parameter int                LANE_W   = 16,
  parameter logic [LANE_W-1:0] ACC_INIT = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [3:0]                opcode,
  input  logic [LANES*LANE_W-1:0]   op_1,
  input  logic [LANES*LANE_W-1:0]   op_2,
  output logic                      busy,
  output logic                      done,
  output logic                      illegal,
  output logic [LANES*LANE_W-1:0]   result,
  output logic                      fpu_req,
  output logic                      fpu_op,
  output logic [LANE_W-1:0]         fpu_a,
  output logic [LANE_W-1:0]         fpu_b,
  input  logic                      fpu_ack,
  input  logic [LANE_W-1:0]         fpu_res
);

  localparam int LANE_BITS = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int VEC_W     = LANES * LANE_W;
  localparam logic [3:0] OP_VADD = 4'b0000;
  localparam logic [3:0] OP_VDOT = 4'b0001;
  localparam logic [3:0] OP_SMUL = 4'b0010;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [3:0]           opcode_q;
  logic [VEC_W-1:0]     a_q, b_q, result_q;
  logic [LANE_BITS-1:0] lane_q;
  logic                 phase_q;     // VDOT only: 0 = multiply, 1 = accumulate
  logic                 illegal_q;
  logic [LANE_W-1:0]    acc_q, prod_q;
  logic [LANE_W-1:0]    a_lane, b_lane;
  logic                 lane_last, op_last, is_legal, op_done;

  assign is_legal  = (opcode == OP_VADD) || (opcode == OP_VDOT) || (opcode == OP_SMUL);
  assign lane_last = (lane_q == LANE_BITS'(LANES - 1));
  assign op_last   = lane_last && ((opcode_q != OP_VDOT) || phase_q);
  assign op_done   = (state_q == S_RUN) && fpu_ack;

  always_comb begin
    a_lane = '0;
    b_lane = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LANE_BITS'(i)) begin
        a_lane = a_q[i*LANE_W +: LANE_W];
        b_lane = b_q[i*LANE_W +: LANE_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    fpu_req = 1'b0;
    fpu_op  = 1'b0;
    fpu_a   = '0;
    fpu_b   = '0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = is_legal ? S_RUN : S_DONE;
      end
      S_RUN: begin
        fpu_req = 1'b1;
        case (opcode_q)
          OP_SMUL: begin
            fpu_op = 1'b1;
            fpu_a  = a_q[LANE_W-1:0];
            fpu_b  = b_lane;
          end
          OP_VDOT: begin
            fpu_op = ~phase_q;
            fpu_a  = phase_q ? acc_q : a_lane;
            fpu_b  = phase_q ? prod_q : b_lane;
          end
          default: begin
            fpu_a = a_lane;
            fpu_b = b_lane;
          end
        endcase
        if (fpu_ack && op_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      lane_q    <= '0;
      phase_q   <= 1'b0;
      illegal_q <= 1'b0;
      acc_q     <= '0;
      prod_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        opcode_q  <= opcode;
        a_q       <= op_1;
        b_q       <= op_2;
        result_q  <= '0;
        lane_q    <= '0;
        phase_q   <= 1'b0;
        acc_q     <= ACC_INIT;
        illegal_q <= ~is_legal;
      end else if (op_done) begin
        if (opcode_q == OP_VDOT) begin
          if (!phase_q) begin
            prod_q  <= fpu_res;
            phase_q <= 1'b1;
          end else begin
            acc_q   <= fpu_res;
            phase_q <= 1'b0;
            if (lane_last) result_q <= {{(VEC_W-LANE_W){1'b0}}, fpu_res};
            else           lane_q   <= lane_q + LANE_BITS'(1);
          end
        end else begin
          for (int i = 0; i < LANES; i++) begin
            if (lane_q == LANE_BITS'(i)) result_q[i*LANE_W +: LANE_W] <= fpu_res;
          end
          if (!lane_last) lane_q <= lane_q + LANE_BITS'(1);
        end
      end
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign illegal = done & illegal_q;
  assign result  = result_q;

endmodule

// File: tb/tb_vec_lane_sequencer.sv
// Directed bench for vec_lane_sequencer with a behavioural half-precision FPU responder.
module tb_vec_lane_sequencer;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   opcode;
  logic [255:0] op_1, op_2;
  logic         busy, done, illegal;
  logic [255:0] result;
  logic         fpu_req, fpu_op;
  logic [15:0]  fpu_a, fpu_b;
  logic         fpu_ack;
  logic [15:0]  fpu_res;

  int errors = 0;
  int checks = 0;

  int           done_cyc, done_count, n_acks;
  logic         done_illegal, busy_after, req_seen, stable_ok, a_const;
  logic [15:0]  first_a;
  logic [63:0]  op_seq;
  logic [255:0] done_result, final_result;
  logic         rst_busy, rst_req;
  logic [255:0] rst_result;

  vec_lane_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .op_1(op_1), .op_2(op_2),
    .busy(busy), .done(done), .illegal(illegal), .result(result),
    .fpu_req(fpu_req), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_ack(fpu_ack), .fpu_res(fpu_res)
  );

  always #5 clk = ~clk;

  function automatic real h2r(input logic [15:0] h);
    real r;
    int  e;
    if (h[14:10] == 5'd0) return 0.0;
    r = 1.0 + real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]) - 15;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return h[15] ? -r : r;
  endfunction

  function automatic logic [15:0] r2h(input real r_in);
    real  r;
    int   e, man;
    logic s;
    logic [4:0] e5;
    logic [9:0] m10;
    if (r_in == 0.0) return 16'h0000;
    s = (r_in < 0.0);
    r = s ? -r_in : r_in;
    e = 15;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0)  begin r = r * 2.0; e--; end
    man = $rtoi((r - 1.0) * 1024.0 + 0.5);
    if (man == 1024) begin man = 0; e++; end
    e5  = e[4:0];
    m10 = man[9:0];
    return {s, e5, m10};
  endfunction

  function automatic logic [15:0] fp_model(input logic op, input logic [15:0] a, input logic [15:0] b);
    return op ? r2h(h2r(a) * h2r(b)) : r2h(h2r(a) + h2r(b));
  endfunction

  function automatic logic [255:0] rep(input logic [15:0] v);
    return {16{v}};
  endfunction

  // Cycle 0 is the cycle whose closing edge samples start; outputs are sampled on negedges.
  task automatic drive_op(input logic [3:0] opc, input logic [255:0] a, input logic [255:0] b,
                          input int delay, input int ncyc, input int restart_a,
                          input int restart_b, input int rst_at);
    int          wait_cnt;
    logic [15:0] held_a, held_b;
    logic        held_op;
    wait_cnt = 0; done_cyc = -1; done_count = 0; n_acks = 0;
    done_illegal = 1'b0; busy_after = 1'bx; req_seen = 1'b0; stable_ok = 1'b1; a_const = 1'b1;
    first_a = '0; op_seq = '0; done_result = '0; held_a = '0; held_b = '0; held_op = 1'b0;
    rst_busy = 1'bx; rst_req = 1'bx; rst_result = 'x;
    @(negedge clk);
    opcode = opc; op_1 = a; op_2 = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      if (rst_at > 0 && cyc == rst_at + 1) begin
        rst = 1'b0;
        rst_busy = busy; rst_req = fpu_req; rst_result = result;
      end
      if (done) begin
        done_count++;
        if (done_cyc < 0) begin
          done_cyc = cyc; done_illegal = illegal; done_result = result;
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
      fpu_ack = 1'b0;
      if (fpu_req) begin
        req_seen = 1'b1;
        if (wait_cnt == 0) begin
          held_a = fpu_a; held_b = fpu_b; held_op = fpu_op;
        end else if (fpu_a !== held_a || fpu_b !== held_b || fpu_op !== held_op) begin
          stable_ok = 1'b0;
        end
        if (wait_cnt == delay) begin
          fpu_ack = 1'b1;
          fpu_res = fp_model(fpu_op, fpu_a, fpu_b);
          if (n_acks < 64) op_seq[n_acks] = fpu_op;
          if (n_acks == 0) first_a = fpu_a;
          else if (fpu_a !== first_a) a_const = 1'b0;
          n_acks++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
      if (cyc == restart_a || cyc == restart_b) begin
        start = 1'b1; opcode = 4'b0001; op_1 = ~a;
      end else begin
        start = 1'b0;
      end
      if (cyc == rst_at) rst = 1'b1;
    end
    @(negedge clk);
    start = 1'b0; fpu_ack = 1'b0;
    final_result = result;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL reset_done_illegal: got %b%b expected 00", done, illegal); end
    checks++; if (fpu_req !== 1'b0 || fpu_op !== 1'b0) begin errors++; $display("FAIL reset_fpu_ctl: got %b%b expected 00", fpu_req, fpu_op); end
    checks++; if (fpu_a !== 16'h0 || fpu_b !== 16'h0) begin errors++; $display("FAIL reset_fpu_operands: got %h %h expected 0000 0000", fpu_a, fpu_b); end
    checks++; if (result !== 256'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    rst = 1'b0;
  endtask

  task automatic test_vadd;
    drive_op(4'b0000, rep(16'h3C00), rep(16'h3C00), 0, 20, 0, 0, 0);
    checks++; if (done_cyc !== 17) begin errors++; $display("FAIL vadd_done_cycle: got %0d expected 17", done_cyc); end
    checks++; if (done_result !== rep(16'h4000)) begin errors++; $display("FAIL vadd_result: got %h expected %h", done_result, rep(16'h4000)); end
    checks++; if (done_illegal !== 1'b0) begin errors++; $display("FAIL vadd_illegal: got %b expected 0", done_illegal); end
    checks++; if (n_acks !== 16) begin errors++; $display("FAIL vadd_ack_count: got %0d expected 16", n_acks); end
    checks++; if (done_count !== 1 || busy_after !== 1'b0) begin errors++; $display("FAIL vadd_single_done: got count %0d busy_after %b expected 1 0", done_count, busy_after); end
  endtask

  task automatic test_vdot;
    drive_op(4'b0001, rep(16'h3C00), rep(16'h4000), 0, 36, 0, 0, 0);
    checks++; if (done_cyc !== 33) begin errors++; $display("FAIL vdot_done_cycle: got %0d expected 33", done_cyc); end
    checks++; if (done_result !== {240'h0, 16'h5000}) begin errors++; $display("FAIL vdot_result: got %h expected 5000", done_result); end
    checks++; if (n_acks !== 32) begin errors++; $display("FAIL vdot_ack_count: got %0d expected 32", n_acks); end
    checks++; if (op_seq[31:0] !== 32'h5555_5555) begin errors++; $display("FAIL vdot_op_sequence: got %h expected 55555555", op_seq[31:0]); end
  endtask

  task automatic test_smul;
    drive_op(4'b0010, {240'h0, 16'h4000}, rep(16'h4200), 0, 20, 0, 0, 0);
    checks++; if (done_cyc !== 17) begin errors++; $display("FAIL smul_done_cycle: got %0d expected 17", done_cyc); end
    checks++; if (done_result !== rep(16'h4600)) begin errors++; $display("FAIL smul_result: got %h expected %h", done_result, rep(16'h4600)); end
    checks++; if (a_const !== 1'b1 || first_a !== 16'h4000) begin errors++; $display("FAIL smul_scalar_operand: got const %b first %h expected 1 4000", a_const, first_a); end
  endtask

  task automatic test_vadd_wait;
    drive_op(4'b0000, rep(16'h3C00), rep(16'h3C00), 3, 68, 0, 0, 0);
    checks++; if (done_cyc !== 65) begin errors++; $display("FAIL wait_done_cycle: got %0d expected 65", done_cyc); end
    checks++; if (done_result !== rep(16'h4000)) begin errors++; $display("FAIL wait_result: got %h expected %h", done_result, rep(16'h4000)); end
    checks++; if (stable_ok !== 1'b1) begin errors++; $display("FAIL wait_operand_stable: got %b expected 1", stable_ok); end
    checks++; if (n_acks !== 16) begin errors++; $display("FAIL wait_ack_count: got %0d expected 16", n_acks); end
  endtask

  task automatic test_illegal;
    drive_op(4'b0100, rep(16'h3C00), rep(16'h3C00), 0, 4, 0, 0, 0);
    checks++; if (done_cyc !== 1) begin errors++; $display("FAIL illegal_done_cycle: got %0d expected 1", done_cyc); end
    checks++; if (done_illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b expected 1", done_illegal); end
    checks++; if (done_result !== 256'h0) begin errors++; $display("FAIL illegal_result: got %h expected 0", done_result); end
    checks++; if (req_seen !== 1'b0) begin errors++; $display("FAIL illegal_no_req: got %b expected 0", req_seen); end
  endtask

  task automatic test_start_ignored;
    drive_op(4'b0000, rep(16'h3C00), rep(16'h3C00), 0, 24, 5, 17, 0);
    checks++; if (done_count !== 1 || done_cyc !== 17) begin errors++; $display("FAIL busy_start_done: got count %0d cycle %0d expected 1 17", done_count, done_cyc); end
    checks++; if (final_result !== rep(16'h4000)) begin errors++; $display("FAIL busy_start_result: got %h expected %h", final_result, rep(16'h4000)); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL busy_start_idle: got %b expected 0", busy_after); end
  endtask

  task automatic test_rst_mid_op;
    drive_op(4'b0001, rep(16'h3C00), rep(16'h4000), 0, 14, 0, 0, 8);
    checks++; if (rst_busy !== 1'b0 || rst_req !== 1'b0) begin errors++; $display("FAIL rst_mid_ctl: got busy %b req %b expected 0 0", rst_busy, rst_req); end
    checks++; if (rst_result !== 256'h0) begin errors++; $display("FAIL rst_mid_result: got %h expected 0", rst_result); end
    checks++; if (done_count !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d expected 0", done_count); end
    drive_op(4'b0000, rep(16'h3C00), rep(16'h3C00), 0, 20, 0, 0, 0);
    checks++; if (done_cyc !== 17 || done_result !== rep(16'h4000)) begin errors++; $display("FAIL rst_then_vadd: got cycle %0d result %h expected 17 %h", done_cyc, done_result, rep(16'h4000)); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; opcode = '0; op_1 = '0; op_2 = '0;
    fpu_ack = 1'b0; fpu_res = '0;
    test_reset();
    test_vadd();
    test_vdot();
    test_smul();
    test_vadd_wait();
    test_illegal();
    test_start_ignored();
    test_rst_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
